// File: rtl/rfPhoenixPkg.sv
// Shared constants and types for the rfPhoenix vector writeback stage.
package rfPhoenixPkg;
  localparam int NLANES     = 16;
  localparam int LANE_W     = 32;
  localparam int BEAT_LANES = 4;
  localparam int RID_W      = 6;

  typedef enum logic {VWB_IDLE = 1'b0, VWB_WRITE = 1'b1} vwb_state_t;
  typedef logic [NLANES-1:0] lane_mask_t;
endpackage

// File: rtl/rfphoenix_vwb_beatsel.sv
// Finds the first non-empty write beat at or after a start index, and flags
// whether it is the final non-empty beat of the lane-enable vector.
module rfphoenix_vwb_beatsel #(
  parameter int NLANES     = 16,
  parameter int BEAT_LANES = 4,
  parameter int NBEATS     = NLANES / BEAT_LANES,
  parameter int BW         = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic [BW-1:0]     start,
  input  logic [NLANES-1:0] en,
  output logic [BW-1:0]     beat,
  output logic              found,
  output logic              last
);
  import rfPhoenixPkg::*;

  logic [NBEATS-1:0] nonempty_s;

  // per-beat "any lane enabled" reduction
  always_comb begin
    nonempty_s = {NBEATS{1'b0}};
    for (int b = 0; b < NBEATS; b++) begin
      nonempty_s[b] = |en[b*BEAT_LANES +: BEAT_LANES];
    end
  end

  // single ascending scan: first hit at/after start, then any later hit clears last
  always_comb begin
    beat  = {BW{1'b0}};
    found = 1'b0;
    last  = 1'b1;
    for (int b = 0; b < NBEATS; b++) begin
      if (!found && (BW'(b) >= start) && nonempty_s[b]) begin
        found = 1'b1;
        beat  = BW'(b);
      end else if (found && nonempty_s[b]) begin
        last = 1'b0;
      end else begin
        last = last;
      end
    end
  end
endmodule

// File: rtl/rfphoenix_vec_writeback.sv
// Vector result writeback: predicate masking and beat sequencing into the register file.
// Optional operand forwarding outputs are enabled by defining VWB_FWD_EN.
module rfphoenix_vec_writeback #(
  parameter int NLANES     = rfPhoenixPkg::NLANES,
  parameter int LANE_W     = rfPhoenixPkg::LANE_W,
  parameter int BEAT_LANES = rfPhoenixPkg::BEAT_LANES,
  parameter int RID_W      = rfPhoenixPkg::RID_W,
  localparam int NBEATS    = NLANES / BEAT_LANES,
  localparam int BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [RID_W-1:0]             i_rid,
  input  logic                         i_tt,
  input  logic                         i_zero,
  input  logic [NLANES-1:0]            i_mask,
  input  logic [NLANES*LANE_W-1:0]     i_res,
  output logic                         wr_en,
  output logic [RID_W-1:0]             wr_rid,
  output logic [BW-1:0]                wr_beat,
  output logic [BEAT_LANES-1:0]        wr_lmask,
  output logic [BEAT_LANES*LANE_W-1:0] wr_data,
  output logic                         done,
  output logic [RID_W-1:0]             done_rid,
`ifdef VWB_FWD_EN
  output logic                         fwd_valid,
  output logic [RID_W-1:0]             fwd_rid,
  output logic [NLANES*LANE_W-1:0]     fwd_data,
  output logic [NLANES-1:0]            fwd_en,
`endif
  output logic                         busy
);
  import rfPhoenixPkg::*;

  vwb_state_t                   state_r, state_s;
  logic [RID_W-1:0]             rid_r, rid_s;
  logic [NLANES-1:0]            en_r, en_s, in_en_s, sel_en_s;
  logic [NLANES*LANE_W-1:0]     data_r, data_s, in_data_s, sel_data_s;
  logic                         last_r, last_s;
  logic                         wr_en_s, done_s, xfer_s;
  logic [RID_W-1:0]             wr_rid_s, done_rid_s;
  logic [BW-1:0]                wr_beat_s, scan_start_s, scan_beat_s;
  logic [BEAT_LANES-1:0]        wr_lmask_s, beat_lmask_s;
  logic [BEAT_LANES*LANE_W-1:0] wr_data_s, beat_data_s;
  logic                         scan_found_s, scan_last_s;

  // a presented beat with last_r set is the final write of the current result
  assign i_ready = (state_r == VWB_IDLE) | (wr_en & last_r);
  assign busy    = (state_r != VWB_IDLE);
  assign xfer_s  = i_valid & i_ready;

  // effective lane enable and masked data of the offered result
  always_comb begin
    in_en_s   = {NLANES{1'b0}};
    in_data_s = {(NLANES*LANE_W){1'b0}};
    for (int n = 0; n < NLANES; n++) begin
      if (i_tt) begin
        in_en_s[n] = (n == 0);
        in_data_s[n*LANE_W +: LANE_W] = (n == 0) ? i_res[n*LANE_W +: LANE_W] : {LANE_W{1'b0}};
      end else begin
        in_en_s[n] = i_zero | i_mask[n];
        in_data_s[n*LANE_W +: LANE_W] = i_mask[n] ? i_res[n*LANE_W +: LANE_W] : {LANE_W{1'b0}};
      end
    end
  end

  // a new result scans from beat 0; an in-flight one resumes after the presented beat
  assign sel_en_s     = xfer_s ? in_en_s : en_r;
  assign sel_data_s   = xfer_s ? in_data_s : data_r;
  assign scan_start_s = xfer_s ? {BW{1'b0}} : (wr_beat + BW'(1));
  assign beat_lmask_s = sel_en_s[scan_beat_s*BEAT_LANES +: BEAT_LANES];
  assign beat_data_s  = sel_data_s[scan_beat_s*BEAT_LANES*LANE_W +: BEAT_LANES*LANE_W];

  rfphoenix_vwb_beatsel #(
    .NLANES     (NLANES),
    .BEAT_LANES (BEAT_LANES)
  ) u_beatsel (
    .start (scan_start_s),
    .en    (sel_en_s),
    .beat  (scan_beat_s),
    .found (scan_found_s),
    .last  (scan_last_s)
  );

  // next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    rid_s      = rid_r;
    en_s       = en_r;
    data_s     = data_r;
    last_s     = last_r;
    wr_en_s    = 1'b0;
    wr_rid_s   = wr_rid;
    wr_beat_s  = wr_beat;
    wr_lmask_s = wr_lmask;
    wr_data_s  = wr_data;
    done_s     = 1'b0;
    done_rid_s = done_rid;
    case (state_r)
      VWB_IDLE: begin
        state_s = VWB_IDLE;
      end
      VWB_WRITE: begin
        if (!wr_en) begin
          // all-skipped result whose done was displaced by the previous retirement
          done_s     = 1'b1;
          done_rid_s = rid_r;
          state_s    = VWB_IDLE;
        end else if (!last_r) begin
          wr_en_s    = 1'b1;
          wr_beat_s  = scan_beat_s;
          wr_lmask_s = beat_lmask_s;
          wr_data_s  = beat_data_s;
          last_s     = scan_last_s;
        end else begin
          done_s     = 1'b1;
          done_rid_s = rid_r;
          state_s    = VWB_IDLE;
        end
      end
      default: begin
        state_s = VWB_IDLE;
      end
    endcase
    if (xfer_s) begin
      rid_s  = i_rid;
      en_s   = in_en_s;
      data_s = in_data_s;
      if (scan_found_s) begin
        state_s    = VWB_WRITE;
        wr_en_s    = 1'b1;
        wr_rid_s   = i_rid;
        wr_beat_s  = scan_beat_s;
        wr_lmask_s = beat_lmask_s;
        wr_data_s  = beat_data_s;
        last_s     = scan_last_s;
      end else if (done_s) begin
        state_s = VWB_WRITE;
      end else begin
        done_s     = 1'b1;
        done_rid_s = i_rid;
        state_s    = VWB_IDLE;
      end
    end else begin
      rid_s = rid_s;
    end
  end

  // state, capture and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= VWB_IDLE;
      rid_r    <= {RID_W{1'b0}};
      en_r     <= {NLANES{1'b0}};
      data_r   <= {(NLANES*LANE_W){1'b0}};
      last_r   <= 1'b0;
      wr_en    <= 1'b0;
      wr_rid   <= {RID_W{1'b0}};
      wr_beat  <= {BW{1'b0}};
      wr_lmask <= {BEAT_LANES{1'b0}};
      wr_data  <= {(BEAT_LANES*LANE_W){1'b0}};
      done     <= 1'b0;
      done_rid <= {RID_W{1'b0}};
    end else begin
      state_r  <= state_s;
      rid_r    <= rid_s;
      en_r     <= en_s;
      data_r   <= data_s;
      last_r   <= last_s;
      wr_en    <= wr_en_s;
      wr_rid   <= wr_rid_s;
      wr_beat  <= wr_beat_s;
      wr_lmask <= wr_lmask_s;
      wr_data  <= wr_data_s;
      done     <= done_s;
      done_rid <= done_rid_s;
    end
  end

`ifdef VWB_FWD_EN
  assign fwd_valid = (state_r == VWB_WRITE) & wr_en;
  assign fwd_rid   = rid_r;
  assign fwd_data  = data_r;
  assign fwd_en    = en_r;
`endif
endmodule

// File: tb/tb_rfphoenix_vec_writeback.sv
// Scoreboard bench for rfphoenix_vec_writeback: directed results, queued expectations.
module tb_rfphoenix_vec_writeback;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [5:0]   i_rid = 6'd0;
  logic         i_tt = 1'b0;
  logic         i_zero = 1'b0;
  logic [15:0]  i_mask = 16'h0000;
  logic [511:0] i_res = 512'd0;
  logic         wr_en;
  logic [5:0]   wr_rid;
  logic [1:0]   wr_beat;
  logic [3:0]   wr_lmask;
  logic [127:0] wr_data;
  logic         done;
  logic [5:0]   done_rid;
  logic         busy;

  rfphoenix_vec_writeback dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_rid(i_rid),
    .i_tt(i_tt), .i_zero(i_zero), .i_mask(i_mask), .i_res(i_res),
    .wr_en(wr_en), .wr_rid(wr_rid), .wr_beat(wr_beat), .wr_lmask(wr_lmask),
    .wr_data(wr_data), .done(done), .done_rid(done_rid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [5:0] rid; logic [1:0] beat; logic [3:0] lmask; logic [127:0] data;} wr_t;
  typedef struct {int cyc; logic [5:0] rid;} dn_t;
  typedef struct {int cyc; bit rdy; bit bsy; bit wen; bit dn;} st_t;
  wr_t wq[$];
  dn_t dq[$];
  st_t sq[$];
  wr_t mw;
  dn_t md;
  st_t ms;
  logic [127:0] mb;
  int  errors = 0;
  int  checks = 0;
  bit  fin_req = 1'b0;
  bit  drv_timeout = 1'b0;

  function automatic logic [127:0] lane_bits(input logic [3:0] m);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = {32{m[i]}};
    return r;
  endfunction

  function automatic logic [511:0] ramp();
    logic [511:0] r;
    for (int n = 0; n < 16; n++) r[n*32 +: 32] = 32'(n);
    return r;
  endfunction

  function automatic logic [511:0] fill(input logic [31:0] v);
    logic [511:0] r;
    for (int n = 0; n < 16; n++) r[n*32 +: 32] = v;
    return r;
  endfunction

  // monitor: compares every presented write/done/status probe against the queues
  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got rid=%0d beat=%0d at cyc %0d, required no write", wr_rid, wr_beat, cyc);
      end else begin
        mw = wq.pop_front();
        mb = lane_bits(mw.lmask);
        if (mw.cyc != cyc || mw.rid != wr_rid || mw.beat != wr_beat || mw.lmask != wr_lmask ||
            (wr_data & mb) != (mw.data & mb)) begin
          errors++;
          $display("FAIL wr: got cyc=%0d rid=%0d beat=%0d lmask=%h data=%h, required cyc=%0d rid=%0d beat=%0d lmask=%h data=%h",
                   cyc, wr_rid, wr_beat, wr_lmask, wr_data, mw.cyc, mw.rid, mw.beat, mw.lmask, mw.data);
        end
      end
    end
    if (done) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done_rid=%0d at cyc %0d, required no done", done_rid, cyc);
      end else begin
        md = dq.pop_front();
        if (md.cyc != cyc || md.rid != done_rid) begin
          errors++;
          $display("FAIL done: got cyc=%0d rid=%0d, required cyc=%0d rid=%0d", cyc, done_rid, md.cyc, md.rid);
        end
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      ms = sq.pop_front();
      checks++;
      if (ms.cyc != cyc || ms.rdy != i_ready || ms.bsy != busy || ms.wen != wr_en || ms.dn != done) begin
        errors++;
        $display("FAIL status cyc=%0d: got ready=%0b busy=%0b wr_en=%0b done=%0b, required cyc=%0d ready=%0b busy=%0b wr_en=%0b done=%0b",
                 cyc, i_ready, busy, wr_en, done, ms.cyc, ms.rdy, ms.bsy, ms.wen, ms.dn);
      end
    end
    if (fin_req || cyc > 4000) begin
      checks++;
      if (wq.size() != 0) begin
        errors++;
        $display("FAIL wr_missing: got %0d writes never seen, required 0", wq.size());
      end
      checks++;
      if (dq.size() != 0) begin
        errors++;
        $display("FAIL done_missing: got %0d dones never seen, required 0", dq.size());
      end
      checks++;
      if (drv_timeout || cyc > 4000) begin
        errors++;
        $display("FAIL timeout: got handshake/cycle bound expired at cyc %0d, required completion", cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic ew(input int c, input logic [5:0] rid, input logic [1:0] beat,
                    input logic [3:0] lm, input logic [127:0] d);
    wq.push_back('{c, rid, beat, lm, d});
  endtask

  task automatic ed(input int c, input logic [5:0] rid);
    dq.push_back('{c, rid});
  endtask

  task automatic es(input int c, input bit rdy, input bit bsy, input bit wen, input bit dn);
    sq.push_back('{c, rdy, bsy, wen, dn});
  endtask

  // offers a result; returns at the negedge before the transfer edge with t = first write cycle
  task automatic send(input logic [5:0] rid, input logic tt, input logic zero,
                      input logic [15:0] mask, input logic [511:0] res, output int t);
    int n;
    @(negedge clk);
    i_valid = 1'b1; i_rid = rid; i_tt = tt; i_zero = zero; i_mask = mask; i_res = res;
    n = 0;
    while (!i_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) drv_timeout = 1'b1;
    t = cyc + 1;
  endtask

  task automatic release_in();
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) drv_timeout = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  int t, t5;
  logic [511:0] r;

  initial begin
    repeat (3) @(negedge clk);
    es(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // merge, full mask, lane n = n
    send(6'd1, 1'b0, 1'b0, 16'hFFFF, ramp(), t);
    ew(t,   6'd1, 2'd0, 4'hF, {32'd3, 32'd2, 32'd1, 32'd0});
    ew(t+1, 6'd1, 2'd1, 4'hF, {32'd7, 32'd6, 32'd5, 32'd4});
    ew(t+2, 6'd1, 2'd2, 4'hF, {32'd11, 32'd10, 32'd9, 32'd8});
    ew(t+3, 6'd1, 2'd3, 4'hF, {32'd15, 32'd14, 32'd13, 32'd12});
    ed(t+4, 6'd1);
    release_in();
    wait_idle();

    // merge, mask 00F0: only beat 1
    send(6'd2, 1'b0, 1'b0, 16'h00F0, ramp(), t);
    ew(t, 6'd2, 2'd1, 4'hF, {32'd7, 32'd6, 32'd5, 32'd4});
    ed(t+1, 6'd2);
    es(t,   1'b1, 1'b1, 1'b1, 1'b0);
    es(t+1, 1'b1, 1'b0, 1'b0, 1'b1);
    release_in();
    wait_idle();

    // zeroing, mask 0001, all lanes A5A5A5A5
    send(6'd3, 1'b0, 1'b1, 16'h0001, fill(32'hA5A5A5A5), t);
    ew(t,   6'd3, 2'd0, 4'hF, {32'd0, 32'd0, 32'd0, 32'hA5A5A5A5});
    ew(t+1, 6'd3, 2'd1, 4'hF, 128'd0);
    ew(t+2, 6'd3, 2'd2, 4'hF, 128'd0);
    ew(t+3, 6'd3, 2'd3, 4'hF, 128'd0);
    ed(t+4, 6'd3);
    release_in();
    wait_idle();

    // scalar target, mask ignored
    r = fill(32'hFFFFFFFF);
    r[31:0] = 32'h00001234;
    send(6'd4, 1'b1, 1'b0, 16'h0000, r, t);
    ew(t, 6'd4, 2'd0, 4'h1, {32'd0, 32'd0, 32'd0, 32'h00001234});
    ed(t+1, 6'd4);
    release_in();
    wait_idle();

    // merge, empty mask: no writes, done next cycle, ready stays high
    send(6'd7, 1'b0, 1'b0, 16'h0000, ramp(), t);
    ed(t, 6'd7);
    es(t, 1'b1, 1'b0, 1'b0, 1'b1);
    release_in();
    wait_idle();

    // merge, sparse mask 8421: one lane per beat
    send(6'd8, 1'b0, 1'b0, 16'h8421, ramp(), t);
    ew(t,   6'd8, 2'd0, 4'h1, {32'd3, 32'd2, 32'd1, 32'd0});
    ew(t+1, 6'd8, 2'd1, 4'h2, {32'd7, 32'd6, 32'd5, 32'd4});
    ew(t+2, 6'd8, 2'd2, 4'h4, {32'd11, 32'd10, 32'd9, 32'd8});
    ew(t+3, 6'd8, 2'd3, 4'h8, {32'd15, 32'd14, 32'd13, 32'd12});
    ed(t+4, 6'd8);
    release_in();
    wait_idle();

    // back-to-back: rid 6 accepted on rid 5's last beat, no gap
    send(6'd5, 1'b0, 1'b0, 16'hFFFF, ramp(), t5);
    ew(t5,   6'd5, 2'd0, 4'hF, {32'd3, 32'd2, 32'd1, 32'd0});
    ew(t5+1, 6'd5, 2'd1, 4'hF, {32'd7, 32'd6, 32'd5, 32'd4});
    ew(t5+2, 6'd5, 2'd2, 4'hF, {32'd11, 32'd10, 32'd9, 32'd8});
    ew(t5+3, 6'd5, 2'd3, 4'hF, {32'd15, 32'd14, 32'd13, 32'd12});
    ed(t5+4, 6'd5);
    es(t5+3, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int b = 0; b < 4; b++) begin
      ew(t5+4+b, 6'd6, 2'(b), 4'hF, {4{32'h66660000}});
    end
    ed(t5+8, 6'd6);
    send(6'd6, 1'b0, 1'b0, 16'hFFFF, fill(32'h66660000), t);
    release_in();
    wait_idle();

    // reset during beat 2: nothing further, no done
    send(6'd9, 1'b0, 1'b0, 16'hFFFF, ramp(), t);
    ew(t,   6'd9, 2'd0, 4'hF, {32'd3, 32'd2, 32'd1, 32'd0});
    ew(t+1, 6'd9, 2'd1, 4'hF, {32'd7, 32'd6, 32'd5, 32'd4});
    ew(t+2, 6'd9, 2'd2, 4'hF, {32'd11, 32'd10, 32'd9, 32'd8});
    es(t+3, 1'b1, 1'b0, 1'b0, 1'b0);
    es(t+4, 1'b1, 1'b0, 1'b0, 1'b0);
    release_in();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    fin_req = 1'b1;
  end
endmodule
